// File: rtl/mips_mem_arbiter_pkg.sv
// Shared definitions for the MIPS single-port memory arbiter.
// Holds the width defaults and the response-tracker state encoding.
// The pipeline core can import the same values so both sides agree.
package mips_mem_arbiter_pkg;
  localparam int ADDR_W_DEF       = 10;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  // Which requester owns the read data arriving this cycle
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_F    = 2'd1,
    RSP_D    = 2'd2
  } rsp_state_e;
endpackage

// File: rtl/mips_mem_arbiter_starve_ctr.sv
// mips_starve_ctr: saturating up-counter with synchronous clear.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   i_inc     count up one (holds once LIMIT is reached)
//   i_clr     return to zero; takes priority over i_inc
//   o_sat     counter currently equals LIMIT
module mips_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);
  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = (r_cnt == W'(LIMIT));
  assign o_sat = w_sat;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_inc && !w_sat)
      r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory between the fetch and
// data stages of a MIPS pipeline.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   f_req/f_addr/f_gnt           fetch read request and acceptance
//   f_rvalid/f_rdata             fetch read response (one cycle after grant)
//   flush                        branch taken: drop fetch grant and response
//   d_req/d_we/d_addr/d_wdata    data load/store request
//   d_gnt, d_rvalid/d_rdata      data acceptance and load response
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata          memory port (read data one cycle later)
// Data wins by default; fetch is forced through after STARVE_LIMIT
// consecutive denials. Requests are not buffered.
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  rsp_state_e r_state, w_nxt;
  logic       w_sat, w_f_elig, w_f_gnt, w_d_gnt;

  // Flush and reset both take fetch out of the running for this cycle,
  // so a saturated counter during flush still lets data through.
  assign w_f_elig = f_req && !flush && !rst;
  assign w_f_gnt  = w_f_elig && (w_sat || !d_req);
  assign w_d_gnt  = d_req && !rst && !w_f_gnt;

  mips_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (f_req && !w_f_gnt),
    .i_clr (flush || w_f_gnt || !f_req),
    .o_sat (w_sat)
  );

  assign f_gnt     = w_f_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_en    = w_f_gnt || w_d_gnt;
  assign mem_we    = w_d_gnt && d_we;
  assign mem_addr  = w_f_gnt ? f_addr : d_addr;
  assign mem_wdata = d_wdata;
  assign f_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RSP_NONE;
    else     r_state <= w_nxt;
  end

  // Stores complete at grant, so only loads and fetches leave a response
  // owed for the next cycle. Reset gating covers a read caught in flight.
  always_comb begin
    w_nxt    = RSP_NONE;
    f_rvalid = 1'b0;
    d_rvalid = 1'b0;
    if (w_f_gnt)
      w_nxt = RSP_F;
    else if (w_d_gnt && !d_we)
      w_nxt = RSP_D;
    if (!rst) begin
      f_rvalid = (r_state == RSP_F) && !flush;
      d_rvalid = (r_state == RSP_D);
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
module tb_mips_mem_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst, f_req, flush, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [DW-1:0] f_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .flush(flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory driven by the DUT's port; sm is the bench's shadow.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] sm  [1024];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata     = mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: denial count, owed response, shadow memory.
  int            m_cnt   = 0;
  int            m_pend  = 0;   // 0 none, 1 fetch, 2 data
  logic [DW-1:0] m_pdata = '0;
  logic          m_fg = 1'b0, m_dg = 1'b0;

  always @(negedge clk) begin
    logic ef, ed, efv, edv;
    ef  = !rst && f_req && !flush && (m_cnt == LIM || !d_req);
    ed  = !rst && d_req && !ef;
    efv = !rst && m_pend == 1 && !flush;
    edv = !rst && m_pend == 2;
    chk("f_gnt", {31'b0, f_gnt}, {31'b0, ef});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, ed});
    chk("mem_en", {31'b0, mem_en}, {31'b0, ef || ed});
    chk("mem_we", {31'b0, mem_we}, {31'b0, ed && d_we});
    if (ef) chk("mem_addr_f", {22'b0, mem_addr}, {22'b0, f_addr});
    if (ed) chk("mem_addr_d", {22'b0, mem_addr}, {22'b0, d_addr});
    if (ed && d_we) chk("mem_wdata", mem_wdata, d_wdata);
    chk("f_rvalid", {31'b0, f_rvalid}, {31'b0, efv});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, edv});
    if (efv) chk("f_rdata", f_rdata, m_pdata);
    if (edv) chk("d_rdata", d_rdata, m_pdata);
    chk("f_rdata_pass", f_rdata, mem_rdata);
    chk("d_rdata_pass", d_rdata, mem_rdata);
    // advance to next cycle
    if (rst || flush || !f_req || ef) m_cnt = 0;
    else if (m_cnt < LIM)             m_cnt++;
    m_pend = 0;
    if (ef) begin
      m_pend = 1; m_pdata = sm[f_addr];
    end else if (ed && !d_we) begin
      m_pend = 2; m_pdata = sm[d_addr];
    end else if (ed) begin
      sm[d_addr] = d_wdata;
    end
    m_fg = ef;
    m_dg = ed;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'(i) * 32'h9E37_79B1;
      sm[i]  = mem[i];
    end
    mem[5] = 32'h1234_5678;
    sm[5]  = 32'h1234_5678;
    rst = 1; f_req = 1; flush = 0; d_req = 1; d_we = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    cyc();
    @(negedge clk);
    chk("rst_f_gnt", {31'b0, f_gnt}, 32'd0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);

    // single fetch, first cycle out of reset
    cyc(); rst = 0; d_req = 0; f_addr = 10'd5;
    @(negedge clk);
    chk("fetch_gnt", {31'b0, f_gnt}, 32'd1);
    chk("fetch_addr", {22'b0, mem_addr}, 32'd5);
    cyc(); f_req = 0;
    @(negedge clk);
    chk("fetch_rvalid", {31'b0, f_rvalid}, 32'd1);
    chk("fetch_rdata", f_rdata, 32'h1234_5678);

    // starvation: four data grants then a forced fetch, repeating
    cyc(); f_req = 1; f_addr = 10'd7; d_req = 1; d_we = 0; d_addr = 10'd9;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      chk("starve_f_gnt", {31'b0, f_gnt}, {31'b0, (k % 5) == 4});
      chk("starve_d_gnt", {31'b0, d_gnt}, {31'b0, (k % 5) != 4});
    end

    // store
    cyc(); f_req = 0; d_req = 1; d_we = 1; d_addr = 10'd3; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_gnt", {31'b0, d_gnt}, 32'd1);
    chk("st_we", {31'b0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_addr", {22'b0, mem_addr}, 32'd3);
    cyc(); d_req = 0; d_we = 0;
    @(negedge clk);
    chk("st_no_rvalid", {31'b0, d_rvalid}, 32'd0);

    // flush right after a fetch grant
    cyc(); f_req = 1; f_addr = 10'd5;
    @(negedge clk);
    chk("fl_pre_gnt", {31'b0, f_gnt}, 32'd1);
    cyc(); flush = 1; d_req = 1; d_addr = 10'd9;
    @(negedge clk);
    chk("fl_rvalid", {31'b0, f_rvalid}, 32'd0);
    chk("fl_f_gnt", {31'b0, f_gnt}, 32'd0);
    chk("fl_d_gnt", {31'b0, d_gnt}, 32'd1);
    cyc(); flush = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      chk("fl_cnt_f_gnt", {31'b0, f_gnt}, {31'b0, k == 4});
    end

    // reset with a load in flight
    cyc(); f_req = 0; d_req = 1; d_we = 0; d_addr = 10'd9;
    @(negedge clk);
    chk("rl_gnt", {31'b0, d_gnt}, 32'd1);
    cyc(); rst = 1;
    @(negedge clk);
    chk("rl_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rl_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rl_d_gnt", {31'b0, d_gnt}, 32'd0);
    cyc(); rst = 0; d_req = 0;
    @(negedge clk);
    chk("rl_after", {31'b0, d_rvalid}, 32'd0);

    // alternating fetch / load
    for (int k = 0; k < 8; k++) begin
      cyc();
      f_req = (k % 2) == 0; d_req = (k % 2) == 1; d_we = 0;
      f_addr = 10'(k); d_addr = 10'(k + 100);
      @(negedge clk);
      if (k > 0) begin
        chk("alt_f_rvalid", {31'b0, f_rvalid}, {31'b0, (k % 2) == 1});
        chk("alt_d_rvalid", {31'b0, d_rvalid}, {31'b0, (k % 2) == 0});
      end
    end
    cyc(); f_req = 0; d_req = 0;

    // random traffic, requesters hold until granted
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (!f_req || m_fg) begin
        f_req  = $urandom_range(0, 2) != 0;
        f_addr = 10'($urandom_range(0, 15));
      end
      if (!d_req || m_dg) begin
        d_req   = $urandom_range(0, 1) == 1;
        d_we    = $urandom_range(0, 2) == 0;
        d_addr  = 10'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
    end
    cyc(); rst = 0; flush = 0; f_req = 0; d_req = 0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
